// File: rtl/kbd_pkg.sv
// Shared keypad definitions: key code width, "no key" marker, debounce states and helpers.
package kbd_pkg;

    localparam logic [2:0]  KEY_NONE = 3'b100;
    localparam int unsigned KEY_W    = 4;

    typedef logic [1:0] dbnc_state_t;

    localparam dbnc_state_t IDLE = 2'd0;
    localparam dbnc_state_t CAND = 2'd1;
    localparam dbnc_state_t HELD = 2'd2;
    localparam dbnc_state_t REL  = 2'd3;

    function automatic logic [KEY_W-1:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Bit 2 set on either coordinate means the scanner saw no key.
    function automatic logic sample_valid(input logic [2:0] row, input logic [2:0] col);
        return !row[2] && !col[2];
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Key-event valid/ready handshake between the debouncer queue and the game FSM.
interface key_event_ctrl_if;
    import kbd_pkg::*;

    logic             evt_valid;
    logic [KEY_W-1:0] evt_key;
    logic             evt_ready;

    modport master (output evt_valid, output evt_key, input evt_ready);
    modport slave  (input evt_valid, input evt_key, output evt_ready);

endinterface

// File: rtl/key_fifo.sv
// Small synchronous FIFO of key codes with a combinational head and a flush input.
module key_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_500k,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [KEY_W-1:0] wdata,
    output logic [KEY_W-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, rd_q;
    logic [KEY_W-1:0] mem_q [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);
    assign head  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_500k or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PW'(1);
            if (pop)  rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk_500k) begin
        if (push && !flush) mem_q[wr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounces scanner coordinates into one-shot key-press events queued for the game FSM.
module key_event_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = 2500,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk_500k,
    input  logic             rst,
    input  logic             enable,
    input  logic [2:0]       row_location,
    input  logic [2:0]       col_location,
    key_event_ctrl_if.master evt,
    output logic             key_held,
    output logic [KEY_W-1:0] held_key,
    output logic             overflow
);

    localparam logic [11:0] CNT_LAST = 12'(DEBOUNCE - 1);

    dbnc_state_t      state_q, state_d;
    logic [11:0]      cnt_q, cnt_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] held_q, held_d;
    logic             press;

    logic             samp_valid;
    logic [KEY_W-1:0] samp_key;
    logic             samp_match;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [KEY_W-1:0] fifo_head;

    assign samp_valid = sample_valid(row_location, col_location);
    assign samp_key   = key_code(row_location[1:0], col_location[1:0]);
    assign samp_match = samp_valid && (samp_key == held_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        held_d  = held_q;
        press   = 1'b0;
        case (state_q)
            IDLE: begin
                if (samp_valid) begin
                    state_d = CAND;
                    cand_d  = samp_key;
                    cnt_d   = 12'd1;
                end
            end
            CAND: begin
                if (!samp_valid) begin
                    state_d = IDLE;
                end else if (samp_key != cand_q) begin
                    cand_d = samp_key;
                    cnt_d  = 12'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    held_d  = cand_q;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            HELD: begin
                if (!samp_match) begin
                    state_d = REL;
                    cnt_d   = 12'd1;
                end
            end
            REL: begin
                // Any other key seen during release must re-debounce from IDLE.
                if (samp_match) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_500k or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            held_q  <= held_d;
        end
    end

    assign key_held = (state_q == HELD) || (state_q == REL);
    assign held_key = key_held ? held_q : '0;

    assign fifo_pop  = evt.evt_valid && evt.evt_ready;
    assign fifo_push = press && enable && (!fifo_full || fifo_pop);

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_500k (clk_500k),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (!enable),
        .wdata    (held_d),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_key   = fifo_empty ? '0 : fifo_head;

    always_ff @(posedge clk_500k or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (!enable) begin
            overflow <= 1'b0;
        end else if (press && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: vector table, corner-case sequences, random vs model.
module tb_key_event_ctrl;
    import kbd_pkg::*;

    localparam int D  = 4;
    localparam int FD = 4;

    logic       clk_500k = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] row, col;
    logic       key_held;
    logic [3:0] held_key;
    logic       overflow;

    key_event_ctrl_if evt_if ();

    key_event_ctrl #(
        .DEBOUNCE   (D),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_500k     (clk_500k),
        .rst          (rst),
        .enable       (enable),
        .row_location (row),
        .col_location (col),
        .evt          (evt_if),
        .key_held     (key_held),
        .held_key     (held_key),
        .overflow     (overflow)
    );

    always #5 clk_500k = ~clk_500k;

    int errors = 0;
    int checks = 0;

    // Reference model: run lengths of identical samples plus a queue of codes.
    int m_q[$];
    bit m_ov;
    int m_held, m_miss, m_run_key, m_run_len;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ov      = 1'b0;
        m_held    = -1;
        m_miss    = 0;
        m_run_key = -1;
        m_run_len = 0;
    endtask

    task automatic model_step(input int s, input bit en, input bit rdy);
        bit pop;
        bit pressed;
        pop     = (m_q.size() > 0) && rdy;
        pressed = 1'b0;
        if (m_held >= 0) begin
            if (s == m_held) m_miss = 0;
            else m_miss++;
            if (m_miss == D) begin
                m_held    = -1;
                m_run_len = 0;
            end
        end else begin
            if (s < 0) m_run_len = 0;
            else if (s == m_run_key && m_run_len > 0) m_run_len++;
            else begin
                m_run_key = s;
                m_run_len = 1;
            end
            if (m_run_len == D) begin
                pressed   = 1'b1;
                m_held    = s;
                m_miss    = 0;
                m_run_len = 0;
            end
        end
        if (!en) begin
            m_q.delete();
            m_ov = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (pressed) begin
                if (m_q.size() < FD) m_q.push_back(s);
                else m_ov = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("evt_valid", int'(evt_if.evt_valid), (m_q.size() > 0) ? 1 : 0);
        chk("evt_key", int'(evt_if.evt_key), (m_q.size() > 0) ? m_q[0] : 0);
        chk("key_held", int'(key_held), (m_held >= 0) ? 1 : 0);
        chk("held_key", int'(held_key), (m_held >= 0) ? m_held : 0);
        chk("overflow", int'(overflow), int'(m_ov));
    endtask

    task automatic drive(input int k, input bit en, input bit rdy);
        if (k < 0) begin
            row = KEY_NONE;
            col = KEY_NONE;
        end else begin
            row = 3'(k >> 2);
            col = 3'(k & 3);
        end
        enable           = en;
        evt_if.evt_ready = rdy;
    endtask

    // One clock: apply inputs, advance model, sample 1 time unit after the edge.
    task automatic cycle(input int k, input bit en, input bit rdy);
        drive(k, en, rdy);
        model_step(k, en, rdy);
        @(posedge clk_500k);
        #1;
        check_model();
    endtask

    task automatic press(input int k, input bit rdy);
        repeat (D + 1) cycle(k, 1'b1, rdy);
        repeat (D + 1) cycle(-1, 1'b1, rdy);
    endtask

    typedef struct {
        int key;
        bit en;
        bit rdy;
        bit ev;
        int ek;
        bit kh;
        int hk;
        bit ov;
    } vec_t;

    vec_t tbl[13];
    int   tgt, dur, k;

    initial begin
        // Single press of row 2 / col 1 (code 9) with D=4, then release and one pop.
        tbl = '{
            '{ 9, 1, 0, 0, 0, 0, 0, 0},
            '{ 9, 1, 0, 0, 0, 0, 0, 0},
            '{ 9, 1, 0, 0, 0, 0, 0, 0},
            '{ 9, 1, 0, 1, 9, 1, 9, 0},
            '{ 9, 1, 0, 1, 9, 1, 9, 0},
            '{ 9, 1, 0, 1, 9, 1, 9, 0},
            '{ 9, 1, 0, 1, 9, 1, 9, 0},
            '{ 9, 1, 0, 1, 9, 1, 9, 0},
            '{-1, 1, 0, 1, 9, 1, 9, 0},
            '{-1, 1, 0, 1, 9, 1, 9, 0},
            '{-1, 1, 0, 1, 9, 1, 9, 0},
            '{-1, 1, 0, 1, 9, 0, 0, 0},
            '{-1, 1, 1, 0, 0, 0, 0, 0}
        };

        rst = 1'b1;
        drive(-1, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk_500k);
        #1;
        chk("rst_evt_valid", int'(evt_if.evt_valid), 0);
        chk("rst_evt_key", int'(evt_if.evt_key), 0);
        chk("rst_key_held", int'(key_held), 0);
        chk("rst_held_key", int'(held_key), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        repeat (10) cycle(-1, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            cycle(tbl[i].key, tbl[i].en, tbl[i].rdy);
            chk("tbl_evt_valid", int'(evt_if.evt_valid), int'(tbl[i].ev));
            chk("tbl_evt_key", int'(evt_if.evt_key), tbl[i].ek);
            chk("tbl_key_held", int'(key_held), int'(tbl[i].kh));
            chk("tbl_held_key", int'(held_key), tbl[i].hk);
            chk("tbl_overflow", int'(overflow), int'(tbl[i].ov));
        end

        // Bounce: a one-sample dropout restarts the debounce count.
        repeat (3) cycle(5, 1'b1, 1'b0);
        cycle(-1, 1'b1, 1'b0);
        repeat (3) cycle(5, 1'b1, 1'b0);
        chk("bounce_early", int'(evt_if.evt_valid), 0);
        cycle(5, 1'b1, 1'b0);
        chk("bounce_valid", int'(evt_if.evt_valid), 1);
        chk("bounce_key", int'(evt_if.evt_key), 5);
        repeat (D + 1) cycle(-1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(i % 2, 1'b1, 1'b0);
        chk("alternate_no_event", int'(evt_if.evt_valid), 0);
        repeat (2) cycle(-1, 1'b1, 1'b0);

        // Overflow and ordering.
        press(1, 1'b0);
        press(2, 1'b0);
        press(3, 1'b0);
        press(4, 1'b0);
        press(6, 1'b0);
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_head", int'(evt_if.evt_key), 1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_order", int'(evt_if.evt_key), i + 1);
            cycle(-1, 1'b1, 1'b1);
        end
        chk("ovf_drained", int'(evt_if.evt_valid), 0);
        cycle(-1, 1'b0, 1'b0);
        chk("ovf_cleared", int'(overflow), 0);

        // Push and pop on the same edge while full.
        press(1, 1'b0);
        press(2, 1'b0);
        press(3, 1'b0);
        press(4, 1'b0);
        repeat (D - 1) cycle(5, 1'b1, 1'b0);
        cycle(5, 1'b1, 1'b1);
        chk("pushpop_no_ovf", int'(overflow), 0);
        chk("pushpop_head", int'(evt_if.evt_key), 2);
        repeat (D + 1) cycle(-1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(-1, 1'b1, 1'b1);
        chk("pushpop_count4", int'(evt_if.evt_valid), 0);

        // Enable flush, then a key held across the enable rise.
        press(7, 1'b0);
        press(8, 1'b0);
        cycle(-1, 1'b0, 1'b0);
        chk("flush_valid", int'(evt_if.evt_valid), 0);
        chk("flush_ovf", int'(overflow), 0);
        repeat (D + 2) cycle(9, 1'b0, 1'b0);
        repeat (6) cycle(9, 1'b1, 1'b0);
        chk("held_across_en", int'(evt_if.evt_valid), 0);
        chk("held_across_kh", int'(key_held), 1);
        repeat (D + 1) cycle(-1, 1'b1, 1'b0);
        press(9, 1'b0);
        chk("repress_valid", int'(evt_if.evt_valid), 1);
        chk("repress_key", int'(evt_if.evt_key), 9);

        // Asynchronous reset mid-debounce with an event queued.
        press(3, 1'b0);
        repeat (D + 1) cycle(3, 1'b1, 1'b0);
        repeat (2) cycle(7, 1'b1, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_evt_valid", int'(evt_if.evt_valid), 0);
        chk("arst_evt_key", int'(evt_if.evt_key), 0);
        chk("arst_key_held", int'(key_held), 0);
        chk("arst_held_key", int'(held_key), 0);
        chk("arst_overflow", int'(overflow), 0);
        repeat (2) @(posedge clk_500k);
        #1 rst = 1'b0;
        repeat (10) cycle(-1, 1'b1, 1'b0);
        chk("arst_no_event", int'(evt_if.evt_valid), 0);

        // Random long-run stimulus with glitches, random ready and rare enable drops.
        tgt = -1;
        dur = 0;
        for (int i = 0; i < 3000; i++) begin
            if (dur == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
                dur = int'($urandom_range(1, 12));
            end
            dur--;
            k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : tgt;
            cycle(k, $urandom_range(0, 31) != 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
